// File: rtl/mux_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the downstream consumer.
interface mux_arbiter_if #(
  parameter int M = 4
);
  logic [M:0] A;
  logic       A_valid;
  logic       A_ready;
  logic [M:0] B;
  logic       B_valid;
  logic       B_ready;
  logic [M:0] Y;
  logic       Y_valid;
  logic       Y_ready;
  logic       S;

  modport slave (
    input  A, A_valid, B, B_valid, Y_ready,
    output A_ready, B_ready, Y, Y_valid, S
  );

  modport master (
    output A, A_valid, B, B_valid, Y_ready,
    input  A_ready, B_ready, Y, Y_valid, S
  );
endinterface

// File: rtl/mux_arbiter.sv
// Two-requester burst-limited arbiter feeding a registered 2:1 mux; one transfer per cycle,
// readies are combinational and drop to zero while the output register is stalled.
module mux_arbiter #(
  parameter int M     = 4,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OWN_A   = 2'd1;
  localparam logic [1:0] OWN_B   = 2'd2;
  localparam logic [3:0] BURST_C = 4'(BURST);

  logic [1:0] owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_a_q, last_a_d;
  logic [M:0] y_q, y_d;
  logic       s_q, s_d;
  logic       yv_q, yv_d;

  logic free, gnt_a, gnt_b, xfer_a, xfer_b, own_hit;

  assign free = !yv_q || bus.Y_ready;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (bus.A_valid && !bus.B_valid) begin
      gnt_a = 1'b1;
    end else if (bus.B_valid && !bus.A_valid) begin
      gnt_b = 1'b1;
    end else if (bus.A_valid && bus.B_valid) begin
      if (owner_q == IDLE) begin
        gnt_a = !last_a_q;
      end else if (cnt_q < BURST_C) begin
        gnt_a = (owner_q == OWN_A);
      end else begin
        // burst exhausted: hand over to whoever did not own the bus
        gnt_a = (owner_q != OWN_A);
      end
      gnt_b = !gnt_a;
    end
  end

  assign bus.A_ready = free && gnt_a;
  assign bus.B_ready = free && gnt_b;
  assign xfer_a      = bus.A_valid && bus.A_ready;
  assign xfer_b      = bus.B_valid && bus.B_ready;
  assign own_hit     = (xfer_a && owner_q == OWN_A) || (xfer_b && owner_q == OWN_B);

  always_comb begin
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    last_a_d = last_a_q;
    y_d      = y_q;
    s_d      = s_q;
    yv_d     = yv_q;
    if (xfer_a || xfer_b) begin
      y_d      = xfer_a ? bus.A : bus.B;
      s_d      = xfer_a;
      yv_d     = 1'b1;
      last_a_d = xfer_a;
      if (own_hit) begin
        cnt_d = (cnt_q >= BURST_C) ? cnt_q : cnt_q + 4'd1;
      end else begin
        owner_d = xfer_a ? OWN_A : OWN_B;
        cnt_d   = 4'd1;
      end
    end else begin
      if (bus.Y_ready) begin
        yv_d = 1'b0;
      end
      if (free && !bus.A_valid && !bus.B_valid) begin
        owner_d = IDLE;
        cnt_d   = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_a_q <= 1'b0;
      y_q      <= '0;
      s_q      <= 1'b0;
      yv_q     <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      last_a_q <= last_a_d;
      y_q      <= y_d;
      s_q      <= s_d;
      yv_q     <= yv_d;
    end
  end

  assign bus.Y       = y_q;
  assign bus.S       = s_q;
  assign bus.Y_valid = yv_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed-vector bench for mux_arbiter; expected words queued at issue, checked by a monitor on consume.
module tb_mux_arbiter;

  typedef struct {
    logic [4:0] y;
    logic       s;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  exp_t exp_q[$];

  mux_arbiter_if #(.M(4)) bus ();

  mux_arbiter #(.M(4), .BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Drive one cycle's inputs, check the readies, and queue the word expected to be accepted.
  task automatic vec(input logic av, input logic [4:0] ad, input logic bv, input logic [4:0] bd,
                     input logic yr, input logic ear, input logic ebr, input string nm);
    exp_t e;
    bus.A_valid = av;
    bus.A       = ad;
    bus.B_valid = bv;
    bus.B       = bd;
    bus.Y_ready = yr;
    #1;
    chk({nm, " A_ready"}, 8'(bus.A_ready), 8'(ear));
    chk({nm, " B_ready"}, 8'(bus.B_ready), 8'(ebr));
    if (!rst && ear && av) begin
      e.y = ad; e.s = 1'b1; exp_q.push_back(e);
    end
    if (!rst && ebr && bv) begin
      e.y = bd; e.s = 1'b0; exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic chk_out(input string nm, input logic yv, input logic [4:0] y, input logic s);
    chk({nm, " Y_valid"}, 8'(bus.Y_valid), 8'(yv));
    chk({nm, " Y"},       8'(bus.Y),       8'(y));
    chk({nm, " S"},       8'(bus.S),       8'(s));
  endtask

  // Monitor: every word consumed downstream must match the oldest queued expectation.
  always @(negedge clk) begin
    chk("one_ready", 8'(bus.A_ready && bus.B_ready), 8'd0);
    if (bus.Y_valid === 1'b1 && bus.Y_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_word", 8'(bus.Y), 8'hFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_Y", 8'(bus.Y), 8'(e.y));
        chk("mon_S", 8'(bus.S), 8'(e.s));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    bus.A = '0; bus.A_valid = 1'b0;
    bus.B = '0; bus.B_valid = 1'b0;
    bus.Y_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_out("reset", 1'b0, 5'h00, 1'b0);
    rst = 1'b0;

    // Single A transfer, then an idle cycle so the next tie goes to B.
    vec(1, 5'h11, 0, 5'h00, 1, 1, 0, "single_a");
    chk_out("single_a_out", 1'b1, 5'h11, 1'b1);
    vec(0, 5'h00, 0, 5'h00, 1, 0, 0, "idle");
    chk("idle Y_valid", 8'(bus.Y_valid), 8'd0);

    // Continuous tie: bursts of four alternating, starting with B.
    for (int i = 0; i < 12; i++) begin
      logic ga;
      ga = ((i / 4) % 2) == 1;
      vec(1, 5'(i), 1, 5'(16 + i), 1, ga, !ga, "tie_rr");
    end

    // Stall with OWN_B exhausted, resume to A, stall again mid-burst.
    vec(1, 5'h05, 1, 5'h15, 0, 0, 0, "stall1");
    vec(1, 5'h06, 1, 5'h16, 0, 0, 0, "stall1");
    chk_out("stall1_hold", 1'b1, 5'h1B, 1'b0);
    vec(1, 5'h06, 1, 5'h16, 1, 1, 0, "resume_a");
    vec(1, 5'h07, 1, 5'h17, 1, 1, 0, "resume_a");
    vec(1, 5'h01, 1, 5'h02, 0, 0, 0, "stall2");
    vec(1, 5'h03, 1, 5'h04, 0, 0, 0, "stall2");
    chk_out("stall2_hold", 1'b1, 5'h07, 1'b1);
    vec(1, 5'h08, 1, 5'h17, 1, 1, 0, "cnt_cont");
    vec(1, 5'h09, 1, 5'h17, 1, 1, 0, "cnt_cont");
    vec(1, 5'h0A, 1, 5'h17, 1, 0, 1, "cnt_cont");
    vec(1, 5'h0A, 1, 5'h18, 1, 0, 1, "cnt_cont");

    // Lone requesters stream without a burst limit.
    for (int i = 0; i < 10; i++) vec(0, 5'h00, 1, 5'(i), 1, 0, 1, "only_b");
    for (int i = 0; i < 6; i++)  vec(1, 5'(20 + i), 0, 5'h00, 1, 1, 0, "only_a");
    vec(1, 5'h1A, 1, 5'h1C, 1, 0, 1, "burst_sat");

    // Build OWN_A with cnt=2, then reset mid-burst.
    vec(1, 5'h1A, 1, 5'h0B, 1, 0, 1, "pre_rst");
    vec(1, 5'h1A, 1, 5'h0C, 1, 0, 1, "pre_rst");
    vec(1, 5'h1A, 1, 5'h0D, 1, 0, 1, "pre_rst");
    vec(1, 5'h12, 1, 5'h0E, 1, 1, 0, "pre_rst");
    vec(1, 5'h13, 1, 5'h0E, 1, 1, 0, "pre_rst");
    rst = 1'b1;
    vec(1, 5'h1F, 1, 5'h1E, 1, 1, 0, "rst_drop");
    rst = 1'b0;
    chk_out("post_rst", 1'b0, 5'h00, 1'b0);
    vec(1, 5'h01, 1, 5'h11, 1, 1, 0, "after_rst");
    vec(1, 5'h02, 1, 5'h12, 1, 1, 0, "after_rst");
    vec(1, 5'h03, 1, 5'h13, 1, 1, 0, "after_rst");
    vec(1, 5'h04, 1, 5'h14, 1, 1, 0, "after_rst");
    vec(1, 5'h05, 1, 5'h15, 1, 0, 1, "after_rst");

    vec(0, 5'h00, 0, 5'h00, 1, 0, 0, "drain");
    vec(0, 5'h00, 0, 5'h00, 1, 0, 0, "drain");
    chk("drain queue_left", 8'(exp_q.size()), 8'd0);
    chk("drain Y_valid", 8'(bus.Y_valid), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
